// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the interrupt controller: cfg_sel targets, FSM states, source bound.
package irq_ctrl_pkg;

    localparam int IRQ_MAX = 16;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_MODE = 2'd1;
    localparam logic [1:0] CFG_CLR  = 2'd2;
    localparam logic [1:0] CFG_SET  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: valid flag plus index of the lowest set bit.
module irq_prio_enc #(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source mask/mode, pending register, fixed-priority req/ack/eoi FSM.
// Edge-mode support is built only when IRQ_CTRL_EDGE_EN is defined; otherwise all sources are level.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter  int NUM_IRQ     = 8,
    parameter  int SYNC_STAGES = 0,
    localparam int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [NUM_IRQ-1:0] cfg_din,
    output logic [NUM_IRQ-1:0] mask_q,
    output logic [NUM_IRQ-1:0] mode_q,
    output logic [NUM_IRQ-1:0] pending_q,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               in_service,
    output irq_state_e         fsm_state
);

    logic [NUM_IRQ-1:0] s_in;
    logic [NUM_IRQ-1:0] rise, mode_chg, sw_set, sw_clr, ack_clr;
    logic [NUM_IRQ-1:0] latch_q, latch_d, pend_d, eligible;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    irq_state_e         state_q, state_d;
    logic               req_d, svc_d;
    logic [ID_W-1:0]    id_d;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= irq_in;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s_in = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s_in = irq_in;
        end
    endgenerate

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_IRQ-1:0] prev_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            mode_q <= '0;
        end else begin
            prev_q <= s_in;
            if (cfg_we && cfg_sel == CFG_MODE) mode_q <= cfg_din;
        end
    end
    assign rise     = s_in & ~prev_q;
    assign mode_chg = (cfg_we && cfg_sel == CFG_MODE) ? (cfg_din ^ mode_q) : '0;
`else
    assign mode_q   = '0;
    assign rise     = '0;
    assign mode_chg = '0;
`endif

    assign sw_set = (cfg_we && cfg_sel == CFG_SET) ? cfg_din : '0;
    assign sw_clr = (cfg_we && cfg_sel == CFG_CLR) ? cfg_din : '0;

    always_comb begin
        ack_clr = '0;
        if (state_q == ST_REQ && irq_ack) ack_clr[irq_id] = mode_q[irq_id];
    end

    // Sets always beat clears so a colliding event is never lost.
    always_comb begin
        latch_d = (latch_q & ~(sw_clr | mode_chg)) | sw_set;
        pend_d  = (mode_q & (rise | sw_set | (pending_q & ~(sw_clr | mode_chg | ack_clr))))
                | (~mode_q & (sw_set | (~mode_chg & (s_in | latch_d))));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '0;
            pending_q <= '0;
            latch_q   <= '0;
        end else begin
            if (cfg_we && cfg_sel == CFG_MASK) mask_q <= cfg_din;
            pending_q <= pend_d;
            latch_q   <= latch_d;
        end
    end

    assign eligible = pending_q & mask_q;

    irq_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // An ack in REQ wins over a same-cycle withdrawal: the CPU saw irq_req high.
    always_comb begin
        state_d = state_q;
        req_d   = irq_req;
        id_d    = irq_id;
        svc_d   = in_service;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    id_d    = win_idx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                    req_d   = 1'b0;
                    svc_d   = 1'b1;
                end else if (!eligible[irq_id]) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi) begin
                    state_d = ST_IDLE;
                    svc_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                svc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_req    <= req_d;
            irq_id     <= id_d;
            in_service <= svc_d;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (NUM_IRQ=8, SYNC_STAGES=0) against a behavioural model.
module tb_irq_controller;
    import irq_ctrl_pkg::*;

    localparam int N = 8;
`ifdef IRQ_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_sel = '0;
    logic [N-1:0] cfg_din = '0;
    logic         irq_ack = 1'b0;
    logic         irq_eoi = 1'b0;
    logic [N-1:0] mask_q, mode_q, pending_q;
    logic         irq_req, in_service;
    logic [2:0]   irq_id;
    irq_state_e   fsm_state;

    irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_din    (cfg_din),
        .mask_q     (mask_q),
        .mode_q     (mode_q),
        .pending_q  (pending_q),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .in_service (in_service),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: software-visible registers plus "requesting"/"servicing" flags.
    bit [N-1:0] m_mask, m_mode, m_pend, m_latch, m_prev;
    bit         m_req, m_svc;
    int         m_id;

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mask = '0; m_mode = '0; m_pend = '0; m_latch = '0; m_prev = '0;
        m_req = 1'b0; m_svc = 1'b0; m_id = 0;
    endtask

    task automatic model_clock();
        bit [N-1:0] elig, setv, clrv, mchg, ackc, latch_n, pend_n;
        elig = m_pend & m_mask;
        ackc = '0;
        setv = (cfg_we && cfg_sel == CFG_SET) ? cfg_din : '0;
        clrv = (cfg_we && cfg_sel == CFG_CLR) ? cfg_din : '0;
        mchg = (EDGE && cfg_we && cfg_sel == CFG_MODE) ? (cfg_din ^ m_mode) : '0;
        if (!m_req && !m_svc) begin
            if (elig != 0) begin
                m_req = 1'b1;
                m_id  = lowest(elig);
            end
        end else if (m_req) begin
            if (irq_ack) begin
                m_req = 1'b0;
                m_svc = 1'b1;
                if (m_mode[m_id]) ackc[m_id] = 1'b1;
            end else if (!elig[m_id]) begin
                m_req = 1'b0;
            end
        end else if (irq_eoi) begin
            m_svc = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            latch_n[i] = setv[i] ? 1'b1 : (clrv[i] || mchg[i]) ? 1'b0 : m_latch[i];
            if (m_mode[i])
                pend_n[i] = ((irq_in[i] && !m_prev[i]) || setv[i]) ? 1'b1 :
                            (clrv[i] || mchg[i] || ackc[i]) ? 1'b0 : m_pend[i];
            else
                pend_n[i] = setv[i] ? 1'b1 : mchg[i] ? 1'b0 : (irq_in[i] || latch_n[i]);
        end
        m_latch = latch_n;
        m_pend  = pend_n;
        m_prev  = irq_in;
        if (cfg_we && cfg_sel == CFG_MASK) m_mask = cfg_din;
        if (EDGE && cfg_we && cfg_sel == CFG_MODE) m_mode = cfg_din;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".mask"}, 32'(mask_q), 32'(m_mask));
        check({tag, ".mode"}, 32'(mode_q), 32'(m_mode));
        check({tag, ".pend"}, 32'(pending_q), 32'(m_pend));
        check({tag, ".req"},  32'(irq_req), 32'(m_req));
        check({tag, ".svc"},  32'(in_service), 32'(m_svc));
        check({tag, ".id"},   32'(irq_id), m_id);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        compare_all(tag);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [N-1:0] din, input string tag);
        cfg_we = 1'b1; cfg_sel = sel; cfg_din = din;
        cycle(tag);
        cfg_we = 1'b0;
    endtask

    task automatic ack_cycle(input string tag);
        irq_ack = 1'b1;
        cycle(tag);
        irq_ack = 1'b0;
    endtask

    task automatic eoi_cycle(input string tag);
        irq_eoi = 1'b1;
        cycle(tag);
        irq_eoi = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 1'b1;

        // Level source 5, held high: re-requests after EOI, not after it drops.
        cfg_write(CFG_MASK, 8'h20, "lvl_mask");
        irq_in = 8'h20;
        cycle("lvl_pend");
        cycle("lvl_req");
        check("lvl_req1", 32'(irq_req), 32'd1);
        check("lvl_id1", 32'(irq_id), 32'd5);
        ack_cycle("lvl_ack");
        check("lvl_svc", 32'(in_service), 32'd1);
        eoi_cycle("lvl_eoi");
        cycle("lvl_rereq");
        check("lvl_req2", 32'(irq_req), 32'd1);
        check("lvl_id2", 32'(irq_id), 32'd5);
        ack_cycle("lvl_ack2");
        irq_in = '0;
        cycle("lvl_drop");
        eoi_cycle("lvl_eoi2");
        cycle("lvl_quiet1");
        cycle("lvl_quiet2");
        check("lvl_noreq", 32'(irq_req), 32'd0);

        // Priority: 2 and 6 together, 0 arrives late and must not pre-empt.
        cfg_write(CFG_MASK, 8'hFF, "pri_mask");
        irq_in = 8'h44;
        cycle("pri_pend");
        cycle("pri_req");
        check("pri_id2", 32'(irq_id), 32'd2);
        irq_in = 8'h45;
        cycle("pri_hold");
        check("pri_stable", 32'(irq_id), 32'd2);
        ack_cycle("pri_ack");
        irq_in = 8'h40;
        cycle("pri_drop");
        eoi_cycle("pri_eoi");
        cycle("pri_req6");
        check("pri_id6", 32'(irq_id), 32'd6);
        irq_in = '0;
        ack_cycle("pri_ack6");
        eoi_cycle("pri_eoi6");
        cycle("pri_idle");

        // Withdrawal by masking, then a late ack is ignored.
        irq_in = 8'h10;
        cycle("wd_pend");
        cycle("wd_req");
        check("wd_id4", 32'(irq_id), 32'd4);
        cfg_write(CFG_MASK, 8'h00, "wd_mask");
        cycle("wd_withdraw");
        check("wd_req0", 32'(irq_req), 32'd0);
        ack_cycle("wd_lateack");
        check("wd_nosvc", 32'(in_service), 32'd0);
        irq_in = '0;
        cycle("wd_idle");

        // Software set of source 7, then clear colliding with a rise on source 0.
        cfg_write(CFG_MASK, 8'hFF, "sw_mask");
        cfg_write(CFG_SET, 8'h80, "sw_set");
        cycle("sw_req");
        check("sw_id7", 32'(irq_id), 32'd7);
        ack_cycle("sw_ack");
        eoi_cycle("sw_eoi");
        irq_in = 8'h01;
        cfg_write(CFG_CLR, 8'h81, "sw_collide");
        check("sw_pend0", 32'(pending_q[0]), 32'd1);
        irq_in = '0;
        repeat (3) cycle("sw_settle");
        if (irq_req) ack_cycle("sw_ack2");
        if (in_service) eoi_cycle("sw_eoi2");

`ifdef IRQ_CTRL_EDGE_EN
        // Edge source 3: one-cycle pulse, ack clears pending, no re-request.
        cfg_write(CFG_MASK, 8'h08, "edge_mask");
        cfg_write(CFG_MODE, 8'h08, "edge_mode");
        irq_in = 8'h08;
        cycle("edge_pend");
        irq_in = '0;
        cycle("edge_req");
        check("edge_id3", 32'(irq_id), 32'd3);
        ack_cycle("edge_ack");
        check("edge_clr", 32'(pending_q), 32'd0);
        eoi_cycle("edge_eoi");
        cycle("edge_q1");
        check("edge_noreq", 32'(irq_req), 32'd0);
`endif

        // Asynchronous reset while in service.
        cfg_write(CFG_MASK, 8'hFF, "rs_mask");
        cfg_write(CFG_SET, 8'h02, "rs_set");
        cycle("rs_req");
        ack_cycle("rs_ack");
        #2 rst = 1'b0;
        #1;
        check("rs_req0", 32'(irq_req), 32'd0);
        check("rs_svc0", 32'(in_service), 32'd0);
        check("rs_pend0", 32'(pending_q), 32'd0);
        check("rs_mask0", 32'(mask_q), 32'd0);
        check("rs_id0", 32'(irq_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        cfg_write(CFG_MODE, 8'hFF, "mode_wr");
        check("mode_val", 32'(mode_q), EDGE ? 32'hFF : 32'h00);

        // Randomised traffic, including spurious acks/eois and config writes.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_din = N'($urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            irq_eoi = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end
        cfg_we = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        cycle("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller for the SoC top level. It replaces the fixed set of seven single-wire CPU interrupt inputs with NUM_IRQ sources. Each source has an individual mask and an optional edge/level mode. Requests are presented to the CPU as one request/acknowledge/end-of-interrupt handshake carrying a fixed-priority source ID, and pending state is readable and writable by software.

## Interface
- NUM_IRQ, 8, number of sources, legal range 1..16
- SYNC_STAGES, 0, synchroniser flops per source for asynchronous inputs, legal range 0..3
- ID_W, derived localparam, $clog2(NUM_IRQ) with a minimum of 1
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-low reset
- irq_in  in  NUM_IRQ  raw source lines, bit i is source i
- cfg_we  in  1  one-cycle configuration write strobe
- cfg_sel  in  2  write target: 0 mask, 1 mode (1 = edge), 2 pending clear (write-1-to-clear), 3 pending set (write-1-to-set, software interrupt)
- cfg_din  in  NUM_IRQ  write data
- mask_q  out  NUM_IRQ  mask register; 1 = enabled
- mode_q  out  NUM_IRQ  mode register
- pending_q  out  NUM_IRQ  pending register
- irq_req  out  1  request to the CPU
- irq_id  out  ID_W  source ID being requested or serviced
- irq_ack  in  1  CPU accepts the request
- irq_eoi  in  1  CPU signals end of interrupt
- in_service  out  1  an interrupt has been acknowledged and no EOI has arrived yet

## Operation
- Synchroniser: when SYNC_STAGES is greater than 0, irq_in passes through SYNC_STAGES flops to give s_in. When it is 0, s_in = irq_in.
- Edge source (mode bit = 1):
  - prev[i] registers s_in[i].
  - A rise (s_in & ~prev) sets pending[i].
  - pending[i] is cleared by irq_ack of source i or by a clear write.
- Level source (mode bit = 0): pending[i] = s_in[i] OR the software-set latch. ACK does not clear it.
- Simultaneous set and clear on the same source in the same cycle: set wins, so no event is lost.
- Eligible sources = pending & mask. The winner is the lowest-index eligible bit, chosen by a priority encoder.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when any source is eligible. irq_id latches the winner and irq_req goes to 1.
  - REQ: irq_id stays stable until the request is accepted or withdrawn.
    - If the latched source is no longer eligible (masked or cleared), the FSM returns to IDLE and irq_req goes to 0. A new arbitration happens in the following cycle.
    - A newly eligible source of higher priority does not pre-empt the latched request.
    - irq_ack in REQ → SERVICE. irq_req goes to 0, in_service goes to 1, and the pending bit is cleared if the source is edge-mode.
  - SERVICE: irq_eoi → IDLE and in_service goes to 0. A level source that is still asserted will request again.
- Ignored handshakes:
  - irq_ack outside REQ is ignored.
  - irq_eoi outside SERVICE is ignored.
  - irq_ack and irq_eoi together in REQ: ack is taken, eoi is ignored.
- Configuration writes take effect at the next clock edge. A mode change clears that source's pending bit.

## Timing
- Reset (rst = 0, asynchronous): mask_q, mode_q, pending_q, prev, the synchronisers, irq_req, irq_id and in_service all go to 0, and the FSM goes to IDLE.
  - Because prev resets to 0, an edge source that is already high when reset is released registers as an edge.
- Latency with SYNC_STAGES = 0: irq_in rises before edge n → pending set at edge n → irq_req = 1 after edge n+1. Each synchroniser stage adds one cycle.
- irq_ack sampled at edge k → irq_req = 0 and in_service = 1 after edge k.
- Back-to-back: EOI at edge k → the next irq_req is no earlier than edge k+1.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- IRQ_CTRL_EDGE_EN:
  - Defined: the mode register and edge detection are present, as described above.
  - Undefined: mode_q is tied to 0, writes with cfg_sel = 1 are ignored, prev is not instantiated, and every source is level-mode.

## Structure
- Package irq_ctrl_pkg holds:
  - the cfg_sel encodings (CFG_MASK, CFG_MODE, CFG_CLR, CFG_SET)
  - the FSM state enum (ST_IDLE, ST_REQ, ST_SERVICE)
  - the NUM_IRQ upper bound constant
- Sub-module irq_prio_enc: parametrised lowest-index-first priority encoder. Output is a valid flag plus an index.

## Test plan
All scenarios use NUM_IRQ = 8 and SYNC_STAGES = 0.
- Edge source 3: mask = 0x08, mode = 0x08, pulse irq_in[3] for 1 cycle → irq_req = 1 and irq_id = 3 two cycles later; after ack, pending_q = 0x00; EOI → in_service = 0 and no re-request.
- Level source 5: mask = 0x20, hold irq_in[5] high, ack then EOI → a second request with irq_id = 5 follows; drop irq_in[5] before the EOI → no second request.
- Priority: sources 2 and 6 pending at the same time, mask = 0xFF → irq_id = 2 first, then 6 after EOI; source 0 raised during the REQ for 2 does not replace irq_id = 2.
- Withdrawal: request for source 4 pending, then write mask = 0x00 before ack → irq_req = 0 the next cycle, and a late irq_ack is ignored.
- Software and collision: cfg_sel = 3 with cfg_din = 0x80 → request with irq_id = 7; clear write of 0x01 in the same cycle as an irq_in[0] rise → pending_q[0] = 1.
- Reset mid-SERVICE: drop rst asynchronously → all outputs 0 immediately; build without IRQ_CTRL_EDGE_EN → mode write of 0xFF leaves mode_q = 0x00.
